// File: rtl/mem_subsystem.sv
// Memory subsystem between the CPU fetch/data ports and on-chip RAM.
// Each port completes through a request/ready handshake with LATENCY
// cycles from acceptance to a one-cycle ready pulse. The two ports run
// either on a true dual-port array or share one port through an arbiter
// (fixed data priority or round-robin).

// Per-port controller: IDLE/WAIT sequencing, wait-state counter and the
// registered ready pulse.
module mem_port_ctrl #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    output logic busy,
    output logic ready
);
    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    // With one wait state the pulse appears in the very first WAIT cycle.
    localparam logic LOAD_READY = (LATENCY == 1) ? 1'b1 : 1'b0;

    logic [0:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic          ready_r;

    // State, counter and ready pulse; ready is set one edge ahead so it
    // is high exactly while the counter reads zero in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= CNT_LOAD;
                        ready_r <= LOAD_READY;
                    end else begin
                        ready_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        ready_r <= (cnt_r == CNT_ONE);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = (state_r == ST_WAIT);
    assign ready = ready_r;
endmodule

module mem_subsystem #(
    parameter int    WORD_CNT  = 1024,
    parameter string MEM_FILE  = "",
    parameter int    LATENCY   = 1,
    parameter int    DUAL_PORT = 1,
    parameter int    ARB_RR    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_mask,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready
);
    localparam int AW = $clog2(WORD_CNT);
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [31:0]   mem [0:WORD_CNT-1];
    logic [AW-1:0] i_idx_s;
    logic [AW-1:0] d_idx_s;
    logic          i_busy_s;
    logic          d_busy_s;
    logic          i_acc_s;
    logic          d_acc_s;
    logic          last_r;
    logic [31:0]   i_rdata_r;
    logic [31:0]   d_rdata_r;
    logic          unused_s;

    // Byte offset and bits above the array size are ignored, so addresses
    // wrap modulo the RAM size.
    assign i_idx_s  = i_addr[AW+1:2];
    assign d_idx_s  = d_addr[AW+1:2];
    assign unused_s = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

    // Acceptance: independent ports, or one grant at a time when shared.
    always_comb begin
        i_acc_s = 1'b0;
        d_acc_s = 1'b0;
        if (!reset) begin
            i_acc_s = 1'b0;
            d_acc_s = 1'b0;
        end else if (DUAL_PORT != 0) begin
            i_acc_s = i_req & ~i_busy_s;
            d_acc_s = d_req & ~d_busy_s;
        end else if (!i_busy_s && !d_busy_s) begin
            if (i_req && d_req) begin
                if ((ARB_RR != 0) && (last_r == GRANT_D)) begin
                    i_acc_s = 1'b1;
                end else begin
                    d_acc_s = 1'b1;
                end
            end else begin
                i_acc_s = i_req;
                d_acc_s = d_req;
            end
        end else begin
            i_acc_s = 1'b0;
            d_acc_s = 1'b0;
        end
    end

    // Remember which port was granted last for round-robin ties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r <= GRANT_I;
        end else if (d_acc_s) begin
            last_r <= GRANT_D;
        end else if (i_acc_s) begin
            last_r <= GRANT_I;
        end else begin
            last_r <= last_r;
        end
    end

    mem_port_ctrl #(.LATENCY(LATENCY)) u_i_ctrl (
        .clk    (clk),
        .reset  (reset),
        .accept (i_acc_s),
        .busy   (i_busy_s),
        .ready  (i_ready)
    );

    mem_port_ctrl #(.LATENCY(LATENCY)) u_d_ctrl (
        .clk    (clk),
        .reset  (reset),
        .accept (d_acc_s),
        .busy   (d_busy_s),
        .ready  (d_ready)
    );

    // Masked data-port writes; the array has no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (d_acc_s && d_we) begin
            for (int b = 0; b < 4; b++) begin
                if (d_mask[b]) begin
                    mem[d_idx_s][8*b +: 8] <= d_wdata[8*b +: 8];
                end
            end
        end
    end

    // Fetch output register: captured at acceptance, so a same-edge data
    // write to that word is not yet visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_rdata_r <= 32'h0000_0000;
        end else if (i_acc_s) begin
            i_rdata_r <= mem[i_idx_s];
        end else begin
            i_rdata_r <= i_rdata_r;
        end
    end

    // Data output register: read word, or zero after a write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_rdata_r <= 32'h0000_0000;
        end else if (d_acc_s) begin
            d_rdata_r <= d_we ? 32'h0000_0000 : mem[d_idx_s];
        end else begin
            d_rdata_r <= d_rdata_r;
        end
    end

    assign i_rdata = i_rdata_r;
    assign d_rdata = d_rdata_r;
endmodule

// File: tb/tb_mem_subsystem.sv
// Bench for mem_subsystem: four configurations side by side (dual-port
// latency 1 and 4, shared fixed-priority latency 2, shared round-robin
// latency 3), directed steps followed by random traffic checked against a
// word-array model with handshake timing derived from the latency rules.
module tb_mem_subsystem;
    localparam int NI = 4;
    localparam int WC  [NI] = '{1024, 16, 16, 16};
    localparam int LAT [NI] = '{1, 4, 2, 3};
    localparam int DP  [NI] = '{1, 1, 0, 0};
    localparam int RR  [NI] = '{0, 0, 0, 1};

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req   [NI];
    logic [31:0] i_addr  [NI];
    logic [31:0] i_rdata [NI];
    logic        i_ready [NI];
    logic        d_req   [NI];
    logic        d_we    [NI];
    logic [3:0]  d_mask  [NI];
    logic [31:0] d_addr  [NI];
    logic [31:0] d_wdata [NI];
    logic [31:0] d_rdata [NI];
    logic        d_ready [NI];

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [31:0] mm [NI][1024];
    bit          last_d   [NI];
    logic [31:0] last_ird [NI];
    int ip_cnt [NI];
    int dp_cnt [NI];
    int exp_ip [NI];
    int exp_dp [NI];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            mem_subsystem #(
                .WORD_CNT (WC[g]),
                .LATENCY  (LAT[g]),
                .DUAL_PORT(DP[g]),
                .ARB_RR   (RR[g])
            ) u_dut (
                .clk    (clk),
                .reset  (reset),
                .i_req  (i_req[g]),
                .i_addr (i_addr[g]),
                .i_rdata(i_rdata[g]),
                .i_ready(i_ready[g]),
                .d_req  (d_req[g]),
                .d_we   (d_we[g]),
                .d_mask (d_mask[g]),
                .d_addr (d_addr[g]),
                .d_wdata(d_wdata[g]),
                .d_rdata(d_rdata[g]),
                .d_ready(d_ready[g])
            );
        end
    endgenerate

    // Count ready pulses seen on every port.
    always @(negedge clk) begin
        for (int n = 0; n < NI; n++) begin
            if (i_ready[n] === 1'b1) ip_cnt[n]++;
            if (d_ready[n] === 1'b1) dp_cnt[n]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input int n, input logic [31:0] a);
        return int'(a[31:2]) % WC[n];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                          input logic [3:0] m);
        logic [31:0] m32;
        m32 = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (old & ~m32) | (w & m32);
    endfunction

    // Raise a request at the current falling edge and wait (bounded) for
    // ready; lat is the number of falling edges until ready, 0 on timeout.
    task automatic run_port(input int n, input bit is_d, input bit we, input logic [3:0] mask,
                            input logic [31:0] a, input logic [31:0] w, input bit keep,
                            output logic [31:0] rd, output int lat);
        int  k;
        bit  done;
        k = 0; done = 1'b0; lat = 0; rd = 32'h0;
        if (is_d) begin
            d_req[n] = 1'b1; d_we[n] = we; d_mask[n] = mask; d_addr[n] = a; d_wdata[n] = w;
        end else begin
            i_req[n] = 1'b1; i_addr[n] = a;
        end
        while (!done && k < 64) begin
            @(negedge clk);
            k++;
            if ((is_d ? d_ready[n] : i_ready[n]) === 1'b1) begin
                done = 1'b1;
                lat  = k;
                rd   = is_d ? d_rdata[n] : i_rdata[n];
            end
        end
        if (!keep) begin
            if (is_d) d_req[n] = 1'b0;
            else      i_req[n] = 1'b0;
        end
    endtask

    task automatic single(input int n, input bit is_d, input bit we, input logic [3:0] mask,
                          input logic [31:0] a, input logic [31:0] w, input string tag,
                          output logic [31:0] got);
        logic [31:0] exp;
        int lat, k;
        k = widx(n, a);
        if (is_d) begin
            exp = we ? 32'h0 : mm[n][k];
            if (we) mm[n][k] = merge(mm[n][k], w, mask);
            exp_dp[n]++;
        end else begin
            exp = mm[n][k];
            last_ird[n] = exp;
            exp_ip[n]++;
        end
        if (DP[n] == 0) last_d[n] = is_d;
        run_port(n, is_d, we, mask, a, w, 1'b0, got, lat);
        chk($sformatf("%s[%0d] latency", tag, n), lat, LAT[n]);
        chk($sformatf("%s[%0d] data", tag, n), got, exp);
        @(negedge clk);
    endtask

    // Both ports request at the same edge.
    task automatic pair(input int n, input bit we, input logic [3:0] mask, input logic [31:0] da,
                        input logic [31:0] dw, input logic [31:0] ia, input string tag,
                        output logic [31:0] got_i);
        logic [31:0] exp_d, exp_i, got_d;
        int  lat_d, lat_i, exp_ld, exp_li, kd, ki;
        bit  d_first;
        kd = widx(n, da);
        ki = widx(n, ia);
        d_first = (DP[n] != 0) ? 1'b0 : ((RR[n] == 0) || !last_d[n]);
        if (d_first) begin
            exp_d = we ? 32'h0 : mm[n][kd];
            if (we) mm[n][kd] = merge(mm[n][kd], dw, mask);
            exp_i = mm[n][ki];
        end else begin
            exp_i = mm[n][ki];
            exp_d = we ? 32'h0 : mm[n][kd];
            if (we) mm[n][kd] = merge(mm[n][kd], dw, mask);
        end
        if (DP[n] != 0) begin
            exp_ld = LAT[n]; exp_li = LAT[n];
        end else begin
            exp_ld = d_first ? LAT[n] : 2 * LAT[n] + 1;
            exp_li = d_first ? 2 * LAT[n] + 1 : LAT[n];
            last_d[n] = !d_first;
        end
        fork
            run_port(n, 1'b1, we, mask, da, dw, 1'b0, got_d, lat_d);
            run_port(n, 1'b0, 1'b0, 4'h0, ia, 32'h0, 1'b0, got_i, lat_i);
        join
        chk($sformatf("%s[%0d] d latency", tag, n), lat_d, exp_ld);
        chk($sformatf("%s[%0d] i latency", tag, n), lat_i, exp_li);
        chk($sformatf("%s[%0d] d data", tag, n), got_d, exp_d);
        chk($sformatf("%s[%0d] i data", tag, n), got_i, exp_i);
        exp_dp[n]++; exp_ip[n]++;
        last_ird[n] = exp_i;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] got, a, ia, w;
        logic [3:0]  mask;
        bit          we;
        bit          q[$];
        int          k, lat, snap, kind;

        reset = 1'b0;
        for (int n = 0; n < NI; n++) begin
            i_req[n] = 1'b0; i_addr[n] = 32'h0;
            d_req[n] = 1'b0; d_we[n] = 1'b0; d_mask[n] = 4'h0;
            d_addr[n] = 32'h0; d_wdata[n] = 32'h0;
            last_d[n] = 1'b0; last_ird[n] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int n = 0; n < NI; n++) begin
            chk($sformatf("reset i_ready[%0d]", n), 32'(i_ready[n]), 32'h0);
            chk($sformatf("reset d_ready[%0d]", n), 32'(d_ready[n]), 32'h0);
            chk($sformatf("reset i_rdata[%0d]", n), i_rdata[n], 32'h0);
            chk($sformatf("reset d_rdata[%0d]", n), d_rdata[n], 32'h0);
        end
        reset = 1'b1;

        // Round-robin: both ports held high, first tie after reset goes to data.
        i_req[3] = 1'b1; i_addr[3] = 32'h0;
        d_req[3] = 1'b1; d_we[3] = 1'b0; d_mask[3] = 4'h0; d_addr[3] = 32'h4;
        k = 0;
        while (q.size() < 8 && k < 200) begin
            @(negedge clk);
            k++;
            if (d_ready[3] === 1'b1) q.push_back(1'b1);
            if (i_ready[3] === 1'b1) q.push_back(1'b0);
        end
        i_req[3] = 1'b0; d_req[3] = 1'b0;
        chk("rr grant count", q.size(), 8);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("rr grant %0d is data", j), 32'(q[j]), 32'((j % 2) == 0));
        end
        exp_dp[3] += 4; exp_ip[3] += 4; last_d[3] = 1'b0;
        @(negedge clk);

        // Fill the words used below on every configuration.
        for (int n = 0; n < NI; n++) begin
            for (int i = 0; i < 16; i++) begin
                single(n, 1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom, "init", got);
            end
        end

        // Latency-1 dual-port basics, byte lanes, wrap and no-op write.
        single(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "wr10", got);
        single(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, "rd10", got);
        chk("rd10 value", got, 32'hDEADBEEF);
        single(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, "wr20", got);
        single(0, 1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000AA00, "lane1", got);
        single(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, "rd20", got);
        chk("lane merge", got, 32'h1122AA44);
        single(0, 1'b1, 1'b0, 4'h0, 32'h23, 32'h0, "rd23", got);
        chk("low bits ignored", got, 32'h1122AA44);
        single(0, 1'b1, 1'b1, 4'hF, 32'h1004, 32'hCAFEF00D, "wr1004", got);
        single(0, 1'b1, 1'b0, 4'h0, 32'h0004, 32'h0, "rd0004", got);
        chk("address wrap", got, 32'hCAFEF00D);
        single(0, 1'b0, 1'b0, 4'h0, 32'h0004, 32'h0, "ird0004", got);
        chk("fetch wrap", got, 32'hCAFEF00D);
        single(0, 1'b1, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, "nopwr", got);
        single(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, "rd10b", got);
        chk("mask0 no-op", got, 32'hDEADBEEF);

        // Latency-4 dual-port same-word conflict.
        single(1, 1'b1, 1'b1, 4'hF, 32'h14, 32'h01234567, "wr14", got);
        pair(1, 1'b1, 4'hF, 32'h14, 32'h89ABCDEF, 32'h14, "conflict", got);
        chk("conflict fetch old", got, 32'h01234567);

        // Shared fixed priority: tie, then data starving fetch.
        pair(2, 1'b0, 4'h0, 32'h8, 32'h0, 32'hC, "tie", got);
        snap = ip_cnt[2];
        i_req[2] = 1'b1; i_addr[2] = 32'h18;
        for (int t = 0; t < 4; t++) begin
            run_port(2, 1'b1, 1'b0, 4'h0, 32'h1C, 32'h0, (t < 3), got, lat);
            chk($sformatf("starve d latency %0d", t), lat, (t == 0) ? LAT[2] : LAT[2] + 1);
            chk($sformatf("starve d data %0d", t), got, mm[2][7]);
        end
        exp_dp[2] += 4;
        chk("starve no fetch", ip_cnt[2] - snap, 0);
        k = 0;
        while (i_ready[2] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("starved fetch latency", k, LAT[2] + 1);
        chk("starved fetch data", i_rdata[2], mm[2][6]);
        i_req[2] = 1'b0; exp_ip[2]++; last_ird[2] = mm[2][6]; last_d[2] = 1'b0;
        @(negedge clk);

        // Reset in the middle of a latency-4 read.
        snap = dp_cnt[1];
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_mask[1] = 4'h0; d_addr[1] = 32'h14;
        repeat (2) @(negedge clk);
        reset = 1'b0; d_req[1] = 1'b0;
        @(negedge clk);
        chk("abort d_ready", 32'(d_ready[1]), 32'h0);
        chk("abort d_rdata", d_rdata[1], 32'h0);
        chk("abort i_rdata", i_rdata[1], 32'h0);
        repeat (4) @(negedge clk);
        chk("abort no pulse", dp_cnt[1] - snap, 0);
        reset = 1'b1;
        for (int n = 0; n < NI; n++) begin
            last_d[n] = 1'b0; last_ird[n] = 32'h0;
        end
        single(1, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0, "reissue", got);
        chk("reissue value", got, 32'h89ABCDEF);

        // Random traffic on every configuration.
        for (int n = 0; n < NI; n++) begin
            for (int it = 0; it < 30; it++) begin
                a  = $urandom; ia = $urandom;
                if (n == 0) begin
                    a  = a  & 32'hFFFF_F03F;
                    ia = ia & 32'hFFFF_F03F;
                end
                kind = int'($urandom_range(0, 2));
                we   = 1'($urandom_range(0, 1));
                mask = 4'($urandom_range(0, 15));
                w    = $urandom;
                case (kind)
                    0:       single(n, 1'b1, we, mask, a, w, "rnd d", got);
                    1:       single(n, 1'b0, 1'b0, 4'h0, ia, 32'h0, "rnd i", got);
                    default: pair(n, we, mask, a, w, ia, "rnd pair", got);
                endcase
            end
        end

        repeat (2) @(negedge clk);
        for (int n = 0; n < NI; n++) begin
            chk($sformatf("i pulses[%0d]", n), ip_cnt[n], exp_ip[n]);
            chk($sformatf("d pulses[%0d]", n), dp_cnt[n], exp_dp[n]);
            chk($sformatf("i_rdata hold[%0d]", n), i_rdata[n], last_ird[n]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
